// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the hazard controller and the pipeline: ID/EX/MEM hazard inputs
// in, per-stage load enables, flush strobes and the stall counter out.
interface pipe_hazard_ctrl_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] Src1;
    logic [REG_W-1:0] Src2;
    logic             Two_Src;
    logic [REG_W-1:0] EX_Dest;
    logic             EX_WB_EN;
    logic             EX_MEM_R_EN;
    logic [REG_W-1:0] MEM_Dest;
    logic             MEM_WB_EN;
    logic             MEM_Req;
    logic             Branch_Taken;

    logic             IF_ld;
    logic             ID_ld;
    logic             EX_ld;
    logic             MEM_ld;
    logic             IF_flush;
    logic             ID_flush;
    logic             Mem_Ready;
    logic [CNT_W-1:0] Stall_Count;

    modport master (
        output Src1, Src2, Two_Src, EX_Dest, EX_WB_EN, EX_MEM_R_EN,
               MEM_Dest, MEM_WB_EN, MEM_Req, Branch_Taken,
        input  IF_ld, ID_ld, EX_ld, MEM_ld, IF_flush, ID_flush, Mem_Ready, Stall_Count
    );

    modport slave (
        input  Src1, Src2, Two_Src, EX_Dest, EX_WB_EN, EX_MEM_R_EN,
               MEM_Dest, MEM_WB_EN, MEM_Req, Branch_Taken,
        output IF_ld, ID_ld, EX_ld, MEM_ld, IF_flush, ID_flush, Mem_Ready, Stall_Count
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: memory-wait stall, RAW hazard stall and branch flush.
// Optional macro FWD_EN: forwarding present, only load-use in EX stalls.
module pipe_hazard_ctrl #(
    parameter int MEM_WAIT = 4,
    parameter int REG_W    = 4,
    parameter int CNT_W    = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    pipe_hazard_ctrl_if.slave    bus
);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [3:0] CNT_INIT = (MEM_WAIT == 0) ? 4'd0 : 4'(MEM_WAIT - 1);
    localparam logic       MEM_WAIT_ZERO = (MEM_WAIT == 0);

    logic [0:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [REG_W-1:0] src1, src2, ex_dest, mem_dest;
    logic             ex_hit, mem_hit, hz;
    logic             mem_stall, mem_ready, hz_stall;

    assign src1     = bus.Src1;
    assign src2     = bus.Src2;
    assign ex_dest  = bus.EX_Dest;
    assign mem_dest = bus.MEM_Dest;

    assign ex_hit  = bus.EX_WB_EN &
                     ((src1 == ex_dest) | (bus.Two_Src & (src2 == ex_dest)));
    assign mem_hit = bus.MEM_WB_EN &
                     ((src1 == mem_dest) | (bus.Two_Src & (src2 == mem_dest)));

`ifdef FWD_EN
    // Forwarding covers everything except a load result still in EX.
    assign hz = bus.EX_MEM_R_EN & ex_hit;
`else
    assign hz = ex_hit | mem_hit;
`endif

    always_comb begin
        mem_stall = 1'b0;
        mem_ready = 1'b0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        if (state_q == RUN) begin
            if (bus.MEM_Req) begin
                if (MEM_WAIT_ZERO) begin
                    mem_ready = 1'b1;
                end else begin
                    mem_stall = 1'b1;
                    state_d   = BUSY;
                    cnt_d     = CNT_INIT;
                end
            end
        end else if (cnt_q != 4'd0) begin
            mem_stall = 1'b1;
            cnt_d     = cnt_q - 4'd1;
        end else begin
            mem_ready = 1'b1;
            state_d   = RUN;
        end
    end

    assign hz_stall = ~mem_stall & ~bus.Branch_Taken & hz;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hz_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Outcome priority: memory freeze, then branch squash, then hazard bubble.
    always_comb begin
        bus.IF_ld     = 1'b1;
        bus.ID_ld     = 1'b1;
        bus.EX_ld     = 1'b1;
        bus.MEM_ld    = 1'b1;
        bus.IF_flush  = 1'b0;
        bus.ID_flush  = 1'b0;
        bus.Mem_Ready = 1'b0;
        if (!RST) begin
            bus.Mem_Ready = mem_ready;
            if (mem_stall) begin
                bus.IF_ld  = 1'b0;
                bus.ID_ld  = 1'b0;
                bus.EX_ld  = 1'b0;
                bus.MEM_ld = 1'b0;
            end else if (bus.Branch_Taken) begin
                bus.IF_flush = 1'b1;
                bus.ID_flush = 1'b1;
            end else if (hz) begin
                bus.IF_ld    = 1'b0;
                bus.ID_ld    = 1'b0;
                bus.ID_flush = 1'b1;
            end
        end
    end

    assign bus.Stall_Count = stall_cnt_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= RUN;
            cnt_q       <= 4'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MEM_WAIT=4); expectations follow FWD_EN when defined.
module tb_pipe_hazard_ctrl;

    logic CLK = 1'b0;
    logic RST;
    int   n_chk = 0;
    int   n_err = 0;
    int   exp_sc = 0;

    always #5 CLK = ~CLK;

    pipe_hazard_ctrl_if #(.REG_W(4), .CNT_W(16)) bus ();

    pipe_hazard_ctrl #(.MEM_WAIT(4), .REG_W(4), .CNT_W(16)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Output vector order: IF_ld ID_ld EX_ld MEM_ld IF_flush ID_flush Mem_Ready
    localparam logic [6:0] O_RUN   = 7'b1111000;
    localparam logic [6:0] O_HZ    = 7'b0011010;
    localparam logic [6:0] O_FRZ   = 7'b0000000;
    localparam logic [6:0] O_BR    = 7'b1111110;
    localparam logic [6:0] O_RDY   = 7'b1111001;
    localparam logic [6:0] O_RDYBR = 7'b1111111;

    function automatic logic [6:0] outs();
        return {bus.IF_ld, bus.ID_ld, bus.EX_ld, bus.MEM_ld,
                bus.IF_flush, bus.ID_flush, bus.Mem_Ready};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        bus.Src1 = '0; bus.Src2 = '0; bus.Two_Src = 1'b0;
        bus.EX_Dest = '0; bus.EX_WB_EN = 1'b0; bus.EX_MEM_R_EN = 1'b0;
        bus.MEM_Dest = '0; bus.MEM_WB_EN = 1'b0; bus.MEM_Req = 1'b0;
        bus.Branch_Taken = 1'b0;
    endtask

    task automatic load_use();
        bus.EX_MEM_R_EN = 1'b1; bus.EX_WB_EN = 1'b1; bus.EX_Dest = 4'd3; bus.Src1 = 4'd3;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        idle();
        RST = 1'b1;
        bus.MEM_Req = 1'b1;
        #2;
        check_eq("reset_outs", 32'(outs()), 32'(O_RUN));
        check_eq("reset_cnt", 32'(bus.Stall_Count), 32'd0);
        tick();
        idle();
        RST = 1'b0;
        #2;
        check_eq("idle_outs", 32'(outs()), 32'(O_RUN));

        // Load-use hazard: one bubble, counter steps
        tick();
        load_use();
        #2;
        check_eq("lu_outs", 32'(outs()), 32'(O_HZ));
        tick();
        exp_sc++;
        idle();
        #2;
        check_eq("lu_cnt", 32'(bus.Stall_Count), 32'(exp_sc));
        check_eq("lu_after", 32'(outs()), 32'(O_RUN));

        // Src2 match ignored unless Two_Src
        tick();
        bus.EX_WB_EN = 1'b1; bus.EX_Dest = 4'd3; bus.Src1 = 4'd0; bus.Src2 = 4'd3;
        #2;
        check_eq("src2_no2src", 32'(outs()), 32'(O_RUN));
        bus.Two_Src = 1'b1;
        #1;
`ifdef FWD_EN
        check_eq("src2_ex_fwd", 32'(outs()), 32'(O_RUN));
`else
        check_eq("src2_ex_nofwd", 32'(outs()), 32'(O_HZ));
        exp_sc++;
`endif
        tick();
        idle();
        #2;
        check_eq("src2_cnt", 32'(bus.Stall_Count), 32'(exp_sc));

        // Branch beats hazard, counter unchanged
        tick();
        load_use();
        bus.Branch_Taken = 1'b1;
        #2;
        check_eq("br_hz_outs", 32'(outs()), 32'(O_BR));
        tick();
        idle();
        #2;
        check_eq("br_hz_cnt", 32'(bus.Stall_Count), 32'(exp_sc));

        // Memory access: 4 frozen cycles, release, then back-to-back re-entry
        tick();
        bus.MEM_Req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #2;
            check_eq($sformatf("mem_frz%0d", k), 32'(outs()), 32'(O_FRZ));
            tick();
        end
        #2;
        check_eq("mem_rdy", 32'(outs()), 32'(O_RDY));
        tick();
        for (int k = 0; k < 4; k++) begin
            #2;
            check_eq($sformatf("b2b_frz%0d", k), 32'(outs()), 32'(O_FRZ));
            tick();
        end
        #2;
        check_eq("b2b_rdy", 32'(outs()), 32'(O_RDY));
        tick();
        idle();

        // Branch and hazard held during BUSY, branch flush on release cycle
        bus.MEM_Req = 1'b1;
        bus.Branch_Taken = 1'b1;
        load_use();
        for (int k = 0; k < 4; k++) begin
            #2;
            check_eq($sformatf("busy_br%0d", k), 32'(outs()), 32'(O_FRZ));
            tick();
        end
        #2;
        check_eq("busy_br_rel", 32'(outs()), 32'(O_RDYBR));
        check_eq("busy_br_cnt", 32'(bus.Stall_Count), 32'(exp_sc));
        tick();
        idle();
        #2;
        check_eq("busy_br_cnt2", 32'(bus.Stall_Count), 32'(exp_sc));

        // Reset in BUSY with cnt=2, then full new sequence
        tick();
        bus.MEM_Req = 1'b1;
        tick();
        tick();
        #2;
        check_eq("pre_rst_frz", 32'(outs()), 32'(O_FRZ));
        RST = 1'b1;
        #1;
        check_eq("rst_busy_outs", 32'(outs()), 32'(O_RUN));
        check_eq("rst_busy_cnt", 32'(bus.Stall_Count), 32'd0);
        RST = 1'b0;
        exp_sc = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq($sformatf("post_rst_frz%0d", k), 32'(outs()), 32'(O_FRZ));
            tick();
            #1;
        end
        #1;
        check_eq("post_rst_rdy", 32'(outs()), 32'(O_RDY));
        tick();
        idle();

        // MEM-stage dependency through Src2
        bus.MEM_WB_EN = 1'b1; bus.MEM_Dest = 4'd5; bus.Src2 = 4'd5; bus.Two_Src = 1'b1;
        bus.Src1 = 4'd1;
        #2;
`ifdef FWD_EN
        check_eq("mem_term_fwd", 32'(outs()), 32'(O_RUN));
`else
        check_eq("mem_term_nofwd", 32'(outs()), 32'(O_HZ));
        exp_sc++;
`endif
        tick();
        idle();
        #2;
        check_eq("mem_term_cnt", 32'(bus.Stall_Count), 32'(exp_sc));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
